// File: rtl/collision_pkg.sv
// Shared types for the border-collision scheduler: coordinate type and FSM states.
package collision_pkg;
  localparam int COORD_W = 11;

  typedef logic signed [COORD_W-1:0] coord_t;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, UPDATE} sched_state_t;
endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set pending bit searching upward from lastIdx+1.
module rr_picker #(
  parameter  int NUM_BALLS = 4,
  localparam int IDX_W     = $clog2(NUM_BALLS)
) (
  input  logic [NUM_BALLS-1:0] pending,
  input  logic [IDX_W-1:0]     lastIdx,
  output logic [IDX_W-1:0]     grantIdx,
  output logic                 anyPending
);

  always_comb begin
    grantIdx   = '0;
    anyPending = |pending;
    // Walk from the farthest candidate back to the nearest so the nearest set bit wins.
    for (int k = NUM_BALLS; k >= 1; k--) begin
      if (pending[IDX_W'((int'(lastIdx) + k) % NUM_BALLS)])
        grantIdx = IDX_W'((int'(lastIdx) + k) % NUM_BALLS);
    end
  end

endmodule

// File: rtl/border_collision_scheduler.sv
// Shares one border-collision resolver among NUM_BALLS balls: latches hits, serves them
// round-robin over a valid/ready request, returns resolved velocities, applies frame hold-off.
//
//   state  | meaning
//   IDLE   | no transaction; grant the next pending ball if any
//   REQ    | request presented to the resolver, waiting for reqReady
//   WAIT   | request accepted, waiting for respValid or timeout
//   UPDATE | one-cycle velocity update strobe to the served ball
module border_collision_scheduler
  import collision_pkg::*;
#(
  parameter  int NUM_BALLS      = 4,
  parameter  int HOLDOFF_FRAMES = 3,
  parameter  int TIMEOUT        = 15,
  localparam int IDX_W          = $clog2(NUM_BALLS)
) (
  input  logic                                    clk,
  input  logic                                    resetN,
  input  logic                                    startOfFrame,
  input  logic [NUM_BALLS-1:0]                    ballDR,
  input  logic                                    borderDR,
  input  logic signed [NUM_BALLS-1:0][COORD_W-1:0] ballPosX,
  input  logic signed [NUM_BALLS-1:0][COORD_W-1:0] ballPosY,
  input  logic signed [NUM_BALLS-1:0][COORD_W-1:0] ballVelX,
  input  logic signed [NUM_BALLS-1:0][COORD_W-1:0] ballVelY,
  output logic                                    reqValid,
  input  logic                                    reqReady,
  output logic [IDX_W-1:0]                        reqIdx,
  output coord_t                                  reqPosX,
  output coord_t                                  reqPosY,
  output coord_t                                  reqVelX,
  output coord_t                                  reqVelY,
  input  logic                                    respValid,
  input  coord_t                                  respVelX,
  input  coord_t                                  respVelY,
  output logic                                    updValid,
  output logic [IDX_W-1:0]                        updIdx,
  output coord_t                                  updVelX,
  output coord_t                                  updVelY,
  output logic                                    busy,
  output logic [7:0]                              dropCount
);

  localparam int HO_W  = $clog2(HOLDOFF_FRAMES + 1);
  localparam int TMO_W = $clog2(TIMEOUT + 1);

  sched_state_t         r_state, w_next;
  logic [NUM_BALLS-1:0] r_pending, w_hit, w_grantMask;
  logic [HO_W-1:0]      r_holdoff [NUM_BALLS];
  logic [IDX_W-1:0]     r_lastIdx, r_reqIdx, w_grantIdx;
  logic                 w_anyPending, w_grant, w_accept, w_resp, w_timeout, w_holdLoad;
  coord_t               r_reqPosX, r_reqPosY, r_reqVelX, r_reqVelY, r_updVelX, r_updVelY;
  logic [TMO_W-1:0]     r_tmo;
  logic [7:0]           r_dropCount;

  rr_picker #(.NUM_BALLS(NUM_BALLS)) u_picker (
    .pending    (r_pending),
    .lastIdx    (r_lastIdx),
    .grantIdx   (w_grantIdx),
    .anyPending (w_anyPending)
  );

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) r_state <= IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_grant   = 1'b0;
    w_accept  = 1'b0;
    w_resp    = 1'b0;
    w_timeout = 1'b0;
    case (r_state)
      IDLE:   if (w_anyPending) begin w_grant = 1'b1; w_next = REQ; end
      REQ:    if (reqReady) begin w_accept = 1'b1; w_next = WAIT; end
      WAIT: begin
        // A response in the terminal cycle beats the timeout.
        if (respValid) begin
          w_resp = 1'b1;
          w_next = UPDATE;
        end else if (r_tmo == TMO_W'(TIMEOUT)) begin
          w_timeout = 1'b1;
          w_next    = IDLE;
        end
      end
      UPDATE: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  assign w_holdLoad  = (r_state == UPDATE) || w_timeout;
  assign w_grantMask = w_grant ? (NUM_BALLS'(1) << w_grantIdx) : '0;

  always_comb begin
    w_hit = '0;
    for (int i = 0; i < NUM_BALLS; i++)
      w_hit[i] = ballDR[i] && borderDR && (r_holdoff[i] == '0) &&
                 !((r_state != IDLE) && (r_reqIdx == IDX_W'(i)));
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_pending <= '0;
      for (int i = 0; i < NUM_BALLS; i++) r_holdoff[i] <= '0;
    end else begin
      r_pending <= (r_pending | w_hit) & ~w_grantMask;
      for (int i = 0; i < NUM_BALLS; i++) begin
        if (w_holdLoad && (r_reqIdx == IDX_W'(i)))
          r_holdoff[i] <= HO_W'(HOLDOFF_FRAMES);
        else if (startOfFrame && (r_holdoff[i] != '0))
          r_holdoff[i] <= r_holdoff[i] - HO_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_lastIdx   <= IDX_W'(NUM_BALLS - 1);
      r_reqIdx    <= '0;
      r_reqPosX   <= '0;
      r_reqPosY   <= '0;
      r_reqVelX   <= '0;
      r_reqVelY   <= '0;
      r_updVelX   <= '0;
      r_updVelY   <= '0;
      r_tmo       <= '0;
      r_dropCount <= '0;
    end else begin
      if (w_grant) begin
        r_reqIdx  <= w_grantIdx;
        r_reqPosX <= ballPosX[w_grantIdx];
        r_reqPosY <= ballPosY[w_grantIdx];
        r_reqVelX <= ballVelX[w_grantIdx];
        r_reqVelY <= ballVelY[w_grantIdx];
      end
      if (w_accept)                r_tmo <= '0;
      else if (r_state == WAIT)    r_tmo <= r_tmo + TMO_W'(1);
      if (w_resp) begin
        r_updVelX <= respVelX;
        r_updVelY <= respVelY;
      end
      if (w_holdLoad)              r_lastIdx <= r_reqIdx;
      if (w_timeout && (r_dropCount != 8'hFF))
        r_dropCount <= r_dropCount + 8'd1;
    end
  end

  assign reqValid  = (r_state == REQ);
  assign updValid  = (r_state == UPDATE);
  assign busy      = (r_state != IDLE);
  assign reqIdx    = r_reqIdx;
  assign updIdx    = r_reqIdx;
  assign reqPosX   = r_reqPosX;
  assign reqPosY   = r_reqPosY;
  assign reqVelX   = r_reqVelX;
  assign reqVelY   = r_reqVelY;
  assign updVelX   = r_updVelX;
  assign updVelY   = r_updVelY;
  assign dropCount = r_dropCount;

endmodule
